// File: rtl/rv32i_types.sv
// Shared types for the instruction/data memory arbiter.
package rv32i_types;

  typedef enum logic [1:0] {
    StIdle,
    StServeI,
    StServeD
  } arb_state_t;

  localparam int unsigned StarveLimitDefault = 4;
  localparam logic [3:0]  BeFull             = 4'hf;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (I-fetch and D-access) onto one shared memory port.
// D has priority; a saturating counter lets a starved I request through.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_read,
  input  logic [31:0] imem_address,
  output logic        imem_resp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_enable,
  output logic        dmem_resp,
  output logic [31:0] dmem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] StarveLim = 3'(STARVE_LIMIT);

  arb_state_t  r_state, w_state_d;
  logic [2:0]  r_starve_cnt, w_starve_cnt_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [3:0]  r_be, w_be_d;
  logic        r_read, w_read_d;
  logic        r_write, w_write_d;

  logic w_i_req, w_d_req, w_grant_i, w_grant_d, w_serving;

  always_comb begin
    w_i_req   = imem_read;
    w_d_req   = dmem_read | dmem_write;
    w_grant_i = w_i_req & (~w_d_req | (r_starve_cnt == StarveLim));
    w_grant_d = w_d_req & ~w_grant_i;
  end

  always_comb begin
    w_state_d      = r_state;
    w_starve_cnt_d = r_starve_cnt;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_be_d         = r_be;
    w_read_d       = r_read;
    w_write_d      = r_write;
    unique case (r_state)
      StIdle: begin
        if (w_grant_i) begin
          w_state_d      = StServeI;
          w_addr_d       = imem_address;
          w_wdata_d      = 32'h0;
          w_be_d         = BeFull;
          w_read_d       = 1'b1;
          w_write_d      = 1'b0;
          w_starve_cnt_d = 3'd0;
        end else if (w_grant_d) begin
          w_state_d = StServeD;
          w_addr_d  = dmem_address;
          w_wdata_d = dmem_wdata;
          w_be_d    = dmem_byte_enable;
          w_read_d  = dmem_read;
          // Read wins if a requester ever raises both, so the port never sees both strobes.
          w_write_d = dmem_write & ~dmem_read;
          if (!w_i_req) begin
            w_starve_cnt_d = 3'd0;
          end else if (r_starve_cnt != 3'h7) begin
            w_starve_cnt_d = r_starve_cnt + 3'd1;
          end
        end else begin
          w_starve_cnt_d = 3'd0;
        end
      end
      StServeI, StServeD: begin
        if (mem_resp) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_starve_cnt <= 3'd0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_be         <= 4'h0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_starve_cnt <= w_starve_cnt_d;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_be         <= w_be_d;
      r_read       <= w_read_d;
      r_write      <= w_write_d;
    end
  end

  // Responses are suppressed if the owner has dropped its request mid-transaction.
  always_comb begin
    w_serving       = (r_state != StIdle);
    mem_read        = w_serving & r_read;
    mem_write       = w_serving & r_write;
    mem_address     = w_serving ? r_addr : 32'h0;
    mem_wdata       = w_serving ? r_wdata : 32'h0;
    mem_byte_enable = w_serving ? r_be : 4'h0;
    imem_resp       = (r_state == StServeI) & mem_resp & w_i_req;
    dmem_resp       = (r_state == StServeD) & mem_resp & w_d_req;
    imem_rdata      = imem_resp ? mem_rdata : 32'h0;
    dmem_rdata      = dmem_resp ? mem_rdata : 32'h0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive D grants allowed while an I request waits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 imem_read  in  1  instruction-side read request; held until imem_resp.
REQ-005 imem_address  in  32  instruction-side address.
REQ-006 imem_resp  out  1  instruction-side transaction complete, one-cycle pulse.
REQ-007 imem_rdata  out  32  instruction-side read data; valid only with imem_resp.
REQ-008 dmem_read, dmem_write  in  1 each  data-side requests; mutually exclusive; held until dmem_resp.
REQ-009 dmem_address, dmem_wdata  in  32 each  data-side address and store data.
REQ-010 dmem_byte_enable  in  4  data-side byte lanes.
REQ-011 dmem_resp  out  1  data-side transaction complete, one-cycle pulse.
REQ-012 dmem_rdata  out  32  data-side read data; valid only with dmem_resp.
REQ-013 mem_read, mem_write  out  1 each  shared-port request strobes; held until mem_resp.
REQ-014 mem_address, mem_wdata  out  32 each  shared-port address and store data.
REQ-015 mem_byte_enable  out  4  shared-port byte lanes; 4'hf for I reads.
REQ-016 mem_resp  in  1  shared-port completion.
REQ-017 mem_rdata  in  32  shared-port read data; valid with mem_resp.

Function
REQ-018 States: IDLE, SERVE_I, SERVE_D; state register only.
REQ-019 IDLE with no request: stay IDLE; all mem_* strobes 0.
REQ-020 IDLE with a request: latch winner's address, wdata, byte_enable and op into hold registers; next state SERVE_I or SERVE_D.
REQ-021 Priority: D wins over I, unless starve_cnt == STARVE_LIMIT with I pending, in which case I wins.
REQ-022 starve_cnt (3 bits, saturating): increments on each D grant while imem_read is 1; clears on any I grant or when imem_read is 0 in IDLE.
REQ-023 SERVE_x: mem_read/mem_write and mem_address/mem_wdata/mem_byte_enable driven only from hold registers; stable until mem_resp.
REQ-024 SERVE_x with mem_resp = 1: same cycle, pulse x_resp and pass mem_rdata to x_rdata combinationally; next state IDLE.
REQ-025 Other side's resp stays 0 and its rdata stays 32'h0 in all cycles.
REQ-026 Latency: request seen in IDLE at cycle t; mem strobe at t+1; x_resp no earlier than t+1. Minimum one IDLE cycle between transactions.
REQ-027 Requester deasserting mid-SERVE: downstream transaction completes from hold registers; x_resp suppressed.
REQ-028 Simultaneous I and D requests in IDLE: one grant only, per REQ-021; loser stays pending, no response.
REQ-029 mem_resp in IDLE: ignored; no state change, no response.
REQ-030 Arbiter never issues mem_read and mem_write in the same cycle.

Reset
REQ-031 rst_n low: state -> IDLE, starve_cnt -> 0, hold registers -> 0, immediately, regardless of clk.
REQ-032 During and after reset until the next grant: all outputs 0 (mem_*, imem_resp, imem_rdata, dmem_resp, dmem_rdata).
REQ-033 Reset mid-SERVE abandons the transaction; no response issued. A late mem_resp after reset is ignored per REQ-029.

Structure
REQ-034 arb_state_t enum and the STARVE_LIMIT default live in shared package rv32i_types.
REQ-035 Single module; no sub-module. Hold registers are inline flops, not register instances.

Verification
REQ-036 Only I read at addr 0x60, mem_resp 2 cycles after mem_read with rdata 0xDEADBEEF -> mem_read at t+1, imem_resp pulse with imem_rdata 0xDEADBEEF, dmem_resp 0.
REQ-037 I read 0x100 and D write 0x200 (wdata 0x12345678, be 4'h3) together -> D served first with mem_wdata 0x12345678 and be 4'h3, then I served with be 4'hf.
REQ-038 D requests back-to-back for 6 transactions, I held pending -> I granted after exactly 4 D grants; starve_cnt cleared after the I grant.
REQ-039 D read at 0x300, dmem_read dropped one cycle into SERVE_D, mem_resp later -> mem_address held at 0x300 until mem_resp; no dmem_resp; return to IDLE.
REQ-040 rst_n low asynchronously mid-SERVE_I -> all outputs 0 before the next clk edge. Then a mem_resp -> no imem_resp.
REQ-041 Spurious mem_resp in IDLE with no requests -> state stays IDLE, no responses.
